// File: rtl/alu_exec_unit.sv
// rtl/alu_exec_unit.sv - multi-cycle ALU execution stage with valid/ready handshakes (optional FAST_SHIFT_EN barrel shifter)
module alu_exec_unit #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [5:0]       alu_funct,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             flag_zero,
    output logic             flag_sign,
    output logic             flag_carry,
    output logic             flag_ovf
);

    localparam logic [5:0] F_ADD = 6'b100000;
    localparam logic [5:0] F_SUB = 6'b100010;
    localparam logic [5:0] F_AND = 6'b100100;
    localparam logic [5:0] F_OR  = 6'b100101;
    localparam logic [5:0] F_XOR = 6'b100110;
    localparam logic [5:0] F_NOT = 6'b100111;
    localparam logic [5:0] F_SLL = 6'b000000;
    localparam logic [5:0] F_SRL = 6'b000010;
    localparam logic [5:0] F_SRA = 6'b000011;

    localparam logic [1:0] ST_IDLE  = 2'd0;
`ifndef FAST_SHIFT_EN
    localparam logic [1:0] ST_SHIFT = 2'd1;
`endif
    localparam logic [1:0] ST_DONE  = 2'd2;

    logic [1:0]       state;
    logic [SHW-1:0]   shamt;
    logic [WIDTH:0]   add_sum;
    logic [WIDTH:0]   sub_sum;
    logic [WIDTH-1:0] alu_val;
    logic             alu_c;
    logic             alu_v;
    logic             alu_upd;
    logic             is_shift;

`ifdef FAST_SHIFT_EN
    logic [WIDTH-1:0] barrel_val;
`else
    logic [SHW-1:0]   count;
    logic [1:0]       shift_kind;
    logic [WIDTH-1:0] shift_step;
`endif

    assign shamt     = op_b[SHW-1:0];
    assign add_sum   = {1'b0, op_a} + {1'b0, op_b};
    // Subtraction as A + ~B + 1 so the top bit reads directly as "no borrow".
    assign sub_sum   = {1'b0, op_a} + {1'b0, ~op_b} + (WIDTH+1)'(1);
    assign in_ready  = (state == ST_IDLE) && !rst;
    assign out_valid = (state == ST_DONE);

    // Decode the function code into a single-cycle result, or flag it as a shift/NOP.
    always_comb begin
        alu_val  = '0;
        alu_c    = 1'b0;
        alu_v    = 1'b0;
        alu_upd  = 1'b1;
        is_shift = 1'b0;
        case (alu_funct)
            F_ADD: begin
                alu_val = add_sum[WIDTH-1:0];
                alu_c   = add_sum[WIDTH];
                alu_v   = (op_a[WIDTH-1] == op_b[WIDTH-1]) && (add_sum[WIDTH-1] != op_a[WIDTH-1]);
            end
            F_SUB: begin
                alu_val = sub_sum[WIDTH-1:0];
                alu_c   = sub_sum[WIDTH];
                alu_v   = (op_a[WIDTH-1] != op_b[WIDTH-1]) && (sub_sum[WIDTH-1] != op_a[WIDTH-1]);
            end
            F_AND: alu_val = op_a & op_b;
            F_OR:  alu_val = op_a | op_b;
            F_XOR: alu_val = op_a ^ op_b;
            F_NOT: alu_val = ~op_a;
            F_SLL, F_SRL, F_SRA: begin
                is_shift = 1'b1;
                alu_upd  = 1'b0;
            end
            default: alu_upd = 1'b0;
        endcase
    end

`ifdef FAST_SHIFT_EN
    // Whole shift in one pass; the low two function bits select left/logical/arithmetic.
    always_comb begin
        barrel_val = op_a;
        case (alu_funct[1:0])
            2'b00:   barrel_val = op_a << shamt;
            2'b10:   barrel_val = op_a >> shamt;
            2'b11:   barrel_val = WIDTH'($signed(op_a) >>> shamt);
            default: barrel_val = op_a;
        endcase
    end
`else
    // One-bit step of the iterative shifter, direction captured at acceptance.
    always_comb begin
        shift_step = result;
        case (shift_kind)
            2'b00:   shift_step = {result[WIDTH-2:0], 1'b0};
            2'b10:   shift_step = {1'b0, result[WIDTH-1:1]};
            2'b11:   shift_step = {result[WIDTH-1], result[WIDTH-1:1]};
            default: shift_step = result;
        endcase
    end
`endif

    // Control FSM plus result/flag registers; reset aborts any shift with no output.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            result     <= '0;
            flag_zero  <= 1'b0;
            flag_sign  <= 1'b0;
            flag_carry <= 1'b0;
            flag_ovf   <= 1'b0;
`ifndef FAST_SHIFT_EN
            count      <= '0;
            shift_kind <= 2'b00;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        if (is_shift) begin
`ifdef FAST_SHIFT_EN
                            result     <= barrel_val;
                            flag_zero  <= (barrel_val == '0);
                            flag_sign  <= barrel_val[WIDTH-1];
                            flag_carry <= 1'b0;
                            flag_ovf   <= 1'b0;
                            state      <= ST_DONE;
`else
                            result     <= op_a;
                            count      <= shamt;
                            shift_kind <= alu_funct[1:0];
                            if (shamt == '0) begin
                                flag_zero  <= (op_a == '0);
                                flag_sign  <= op_a[WIDTH-1];
                                flag_carry <= 1'b0;
                                flag_ovf   <= 1'b0;
                                state      <= ST_DONE;
                            end else begin
                                state <= ST_SHIFT;
                            end
`endif
                        end else begin
                            // NOP and unknown codes still complete so the pipeline advances.
                            if (alu_upd) begin
                                result     <= alu_val;
                                flag_zero  <= (alu_val == '0);
                                flag_sign  <= alu_val[WIDTH-1];
                                flag_carry <= alu_c;
                                flag_ovf   <= alu_v;
                            end
                            state <= ST_DONE;
                        end
                    end
                end
`ifndef FAST_SHIFT_EN
                ST_SHIFT: begin
                    result <= shift_step;
                    count  <= count - SHW'(1);
                    if (count == SHW'(1)) begin
                        flag_zero  <= (shift_step == '0);
                        flag_sign  <= shift_step[WIDTH-1];
                        flag_carry <= 1'b0;
                        flag_ovf   <= 1'b0;
                        state      <= ST_DONE;
                    end
                end
`endif
                ST_DONE: begin
                    if (out_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
// tb/tb_alu_exec_unit.sv - randomized self-checking bench for alu_exec_unit
module tb_alu_exec_unit;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [5:0]  alu_funct;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        flag_zero;
    logic        flag_sign;
    logic        flag_carry;
    logic        flag_ovf;

    int checks;
    int errors;

    logic [31:0] m_r;
    logic [3:0]  m_fl;

    alu_exec_unit #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .alu_funct(alu_funct), .op_a(op_a), .op_b(op_b),
        .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .flag_zero(flag_zero), .flag_sign(flag_sign),
        .flag_carry(flag_carry), .flag_ovf(flag_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: flags {zero,sign,carry,ovf}; NOP/unknown keep the last result.
    task automatic model(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] r, output logic [3:0] fl, output int lat);
        longint ua, ub, sa, sb, s;
        logic c, v;
        int k;
        ua = longint'({32'd0, a});
        ub = longint'({32'd0, b});
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        k = int'(b % 32);
        c = 1'b0;
        v = 1'b0;
        lat = 1;
        r = m_r;
        case (f)
            6'b100000: begin
                s = ua + ub; r = s[31:0]; c = (s > 64'hFFFF_FFFF);
                v = ((sa + sb) != longint'($signed(r)));
            end
            6'b100010: begin
                r = a - b; c = (ua >= ub);
                v = ((sa - sb) != longint'($signed(r)));
            end
            6'b100100: r = a & b;
            6'b100101: r = a | b;
            6'b100110: r = a ^ b;
            6'b100111: r = ~a;
            6'b000000: r = a << k;
            6'b000010: r = a >> k;
            6'b000011: r = $signed(a) >>> k;
            default: begin
                fl = m_fl;
                return;
            end
        endcase
`ifndef FAST_SHIFT_EN
        if (f == 6'b000000 || f == 6'b000010 || f == 6'b000011) lat = k + 1;
`endif
        fl = {(r == 32'd0), r[31], c, v};
        m_r = r;
        m_fl = fl;
    endtask

    // Issue one op, wait for out_valid, capture outputs, then retire it.
    task automatic run_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                          output int lat, output int busy, output logic [31:0] r, output logic [3:0] fl);
        in_valid = 1'b1; alu_funct = f; op_a = a; op_b = b; out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        lat = 1;
        busy = 0;
        while (!out_valid && lat < 100) begin
            if (!in_ready) busy++;
            tick();
            lat++;
        end
        if (!in_ready) busy++;
        checks++;
        if (!out_valid) begin
            errors++;
            $display("FAIL timeout out_valid got %0b exp 1 funct %b", out_valid, f);
        end
        r = result;
        fl = {flag_zero, flag_sign, flag_carry, flag_ovf};
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b1; alu_funct = 6'b100000; op_a = 32'd7; op_b = 32'd9; out_ready = 1'b0;
        repeat (3) tick();
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %b exp 0", in_ready); end
        in_valid = 1'b0;
        rst = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready got %b exp 1", in_ready); end
        checks++;
        if ({out_valid, result, flag_zero, flag_sign, flag_carry, flag_ovf} !== 37'd0) begin
            errors++;
            $display("FAIL reset_state got v=%b r=%h fl=%b%b%b%b exp all 0", out_valid, result,
                     flag_zero, flag_sign, flag_carry, flag_ovf);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_ignored_valid got %b exp 0", out_valid); end
        m_r = 32'd0;
        m_fl = 4'd0;
    endtask

    task automatic test_directed();
        logic [31:0] r, er;
        logic [3:0] fl, efl;
        int lat, busy, elat;
        logic [5:0] codes [6] = '{6'b100000, 6'b100010, 6'b100010, 6'b000011, 6'b000000, 6'b100000};
        logic [31:0] as [6] = '{32'h7FFFFFFF, 32'd5, 32'd3, 32'h80000000, 32'hDEADBEEF, 32'h1200};
        logic [31:0] bs [6] = '{32'd1, 32'd5, 32'd5, 32'd4, 32'd32, 32'h34};
        logic [31:0] rs [6] = '{32'h80000000, 32'd0, 32'hFFFFFFFE, 32'hF8000000, 32'hDEADBEEF, 32'h1234};
        logic [3:0] fs [6] = '{4'b0101, 4'b1010, 4'b0100, 4'b0100, 4'b0100, 4'b0000};
        for (int i = 0; i < 6; i++) begin
            model(codes[i], as[i], bs[i], er, efl, elat);
            run_op(codes[i], as[i], bs[i], lat, busy, r, fl);
            checks++;
            if (r !== rs[i] || fl !== fs[i]) begin
                errors++;
                $display("FAIL directed_%0d got r=%h fl=%b exp r=%h fl=%b", i, r, fl, rs[i], fs[i]);
            end
            checks++;
            if (lat !== elat || busy !== elat) begin
                errors++;
                $display("FAIL directed_lat_%0d got lat=%0d busy=%0d exp %0d", i, lat, busy, elat);
            end
        end
        for (int i = 0; i < 2; i++) begin
            run_op(i == 0 ? 6'b111111 : 6'b010101, 32'hFFFF, 32'hFFFF, lat, busy, r, fl);
            checks++;
            if (r !== 32'h1234 || fl !== 4'b0000 || lat !== 1) begin
                errors++;
                $display("FAIL nop_%0d got r=%h fl=%b lat=%0d exp r=00001234 fl=0000 lat=1", i, r, fl, lat);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] er;
        logic [3:0] efl;
        int elat;
        model(6'b100100, 32'hF0F0F0F0, 32'h0FF00FF0, er, efl, elat);
        in_valid = 1'b1; alu_funct = 6'b100100; op_a = 32'hF0F0F0F0; op_b = 32'h0FF00FF0; out_ready = 1'b0;
        tick();
        alu_funct = 6'b100000;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || result !== 32'h00F000F0) begin
                errors++;
                $display("FAIL backpressure_%0d got v=%b rdy=%b r=%h exp v=1 rdy=0 r=00f000f0",
                         i, out_valid, in_ready, result);
            end
            tick();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || result !== er) begin
            errors++;
            $display("FAIL backpressure_release got v=%b rdy=%b r=%h exp v=0 rdy=1 r=%h",
                     out_valid, in_ready, result, er);
        end
    endtask

    task automatic test_reset_mid_shift();
        int seen;
        in_valid = 1'b1; alu_funct = 6'b000000; op_a = 32'd1; op_b = 32'd20; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (4) tick();
        rst = 1'b1;
        tick();
        checks++;
        if (out_valid !== 1'b0 || result !== 32'd0 || {flag_zero, flag_sign, flag_carry, flag_ovf} !== 4'd0) begin
            errors++;
            $display("FAIL midshift_reset got v=%b r=%h exp v=0 r=00000000 flags 0", out_valid, result);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL midshift_ready got %b exp 1", in_ready); end
        seen = 0;
        repeat (30) begin
            tick();
            if (out_valid) seen++;
        end
        checks++;
        if (seen !== 0) begin errors++; $display("FAIL midshift_no_output got %0d exp 0", seen); end
        out_ready = 1'b0;
        m_r = 32'd0;
        m_fl = 4'd0;
    endtask

    task automatic test_back_to_back();
        logic [31:0] er;
        logic [3:0] efl;
        int elat, pulses, both;
        op_a = $urandom; op_b = $urandom;
        model(6'b100000, op_a, op_b, er, efl, elat);
        in_valid = 1'b1; alu_funct = 6'b100000; out_ready = 1'b1;
        pulses = 0;
        both = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (out_valid) pulses++;
            if (out_valid && in_ready) both++;
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        checks++;
        if (pulses !== 10 || both !== 0) begin
            errors++;
            $display("FAIL back_to_back got pulses=%0d overlap=%0d exp 10 and 0", pulses, both);
        end
        checks++;
        if (result !== er || {flag_zero, flag_sign, flag_carry, flag_ovf} !== efl) begin
            errors++;
            $display("FAIL back_to_back_result got %h exp %h", result, er);
        end
    endtask

    task automatic test_random();
        logic [5:0] pool [10] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b100110,
                                  6'b100111, 6'b000000, 6'b000010, 6'b000011, 6'b111111};
        logic [31:0] a, b, r, er;
        logic [3:0] fl, efl;
        logic [5:0] f;
        int lat, busy, elat;
        for (int i = 0; i < 60; i++) begin
            f = ($urandom_range(0, 7) == 0) ? 6'($urandom) : pool[$urandom_range(0, 9)];
            a = ($urandom_range(0, 9) == 0) ? 32'd0 : $urandom;
            b = ($urandom_range(0, 4) == 0) ? a : $urandom;
            model(f, a, b, er, efl, elat);
            run_op(f, a, b, lat, busy, r, fl);
            checks++;
            if (r !== er || fl !== efl || lat !== elat || busy !== elat) begin
                errors++;
                $display("FAIL random_%0d f=%b a=%h b=%h got r=%h fl=%b lat=%0d busy=%0d exp r=%h fl=%b lat=%0d",
                         i, f, a, b, r, fl, lat, busy, er, efl, elat);
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        m_r = 32'd0;
        m_fl = 4'd0;
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_mid_shift();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
Multi-cycle ALU execution stage directly downstream of the ALU controller; consumes the 6-bit ALU function code plus two operands and produces a registered result and condition flags. Logic ops and add/sub complete in one cycle. Shifts run on an iterative 1-bit-per-cycle shifter. A valid/ready handshake on both sides lets the processor datapath stall while a shift is in progress.

Parameters:
WIDTH, 32, operand/result width in bits (power of 2, >= 8)
SHW, $clog2(WIDTH), shift-amount width taken from op_b[SHW-1:0]

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  reset, synchronous, active-high
in_valid  input  1  request valid
in_ready  output  1  unit can accept; = (state==IDLE) && !rst
alu_funct  input  6  function code from ALU controller
op_a  input  WIDTH  operand A / shift source
op_b  input  WIDTH  operand B / shift amount in [SHW-1:0]
out_valid  output  1  result/flags valid
out_ready  input  1  consumer accepts result
result  output  WIDTH  registered result
flag_zero  output  1  result == 0
flag_sign  output  1  result[WIDTH-1]
flag_carry  output  1  carry out (ADD), no-borrow (SUB), else 0
flag_ovf  output  1  signed overflow (ADD/SUB), else 0

Behaviour:
- Reset (rst high at clock edge): state=IDLE; out_valid=0; result=0; all flags=0; shift counter=0. Overrides any in-progress op; an aborted shift produces no output. in_valid ignored while rst high.
- Accept: in_valid && in_ready at an edge latches alu_funct, op_a, op_b.
- Function codes: 100000 ADD; 100010 SUB (A + ~B + 1, carry = bit WIDTH of that sum); 100100 AND; 100101 OR; 100110 XOR; 100111 NOT (~A, B ignored); 000000 SLL; 000010 SRL; 000011 SRA (sign-fill); 111111 NOP. Any other code is treated as NOP.
- NOP: completes like a 1-cycle op. result and flags keep their previous values; out_valid still asserts, so the pipeline advances.
- Overflow: ADD -> A,B same sign and result sign differs. SUB -> A,B signs differ and result sign differs from A.
- States: IDLE, SHIFT, DONE.
  - IDLE + accept of non-shift op: result/flags computed and registered at the accepting edge; -> DONE. out_valid is high the cycle after acceptance (latency 1).
  - IDLE + accept of shift with k=op_b[SHW-1:0]: result<=op_a, count<=k. If k==0 -> DONE (latency 1, result=op_a). Else -> SHIFT.
  - SHIFT: each cycle result shifts 1 bit in the selected direction and count decrements. On the edge where count goes 1->0 -> DONE. out_valid rises k+1 cycles after acceptance. Flags are updated from the final value on entering DONE; carry=0, ovf=0.
  - DONE: out_valid=1; result/flags held stable while out_ready=0. When out_valid && out_ready -> IDLE, and out_valid=0 next cycle. No new acceptance in the same cycle; back-to-back throughput is one op per 2 cycles minimum.
- in_ready=0 in SHIFT and DONE; in_valid during those states is not consumed.
- Shift amount bits above SHW-1 are ignored (op_b=33 with WIDTH=32 shifts by 1).

Optional Feature:
FAST_SHIFT_EN. Defined: shifts use a combinational barrel shifter and complete with latency 1 like other ops; SHIFT state and counter are not built. Undefined: iterative shifter as above, latency k+1.

Test Plan:
- Reset mid-shift: SLL A=1, B=20, assert rst at cycle 5 -> next cycle out_valid=0, result=0, in_ready=1 after rst drops; no result delivered.
- ADD 0x7FFFFFFF+0x00000001, out_ready=1 -> out_valid 1 cycle later, result=0x80000000, sign=1, ovf=1, carry=0, zero=0.
- SUB 5-5 -> result=0, zero=1, carry=1, ovf=0. Then SUB 3-5 -> result=0xFFFFFFFE, carry=0, sign=1.
- SRA A=0x80000000, B=4 (no FAST_SHIFT_EN) -> in_ready low 5 cycles, out_valid at cycle 5, result=0xF8000000. Same with FAST_SHIFT_EN -> cycle 1.
- Backpressure: AND 0xF0F0F0F0 & 0x0FF00FF0 with out_ready=0 for 4 cycles -> result=0x00F000F0 held stable, in_ready=0 throughout, IDLE the cycle after out_ready=1.
- NOP (111111) and undefined code 010101 after ADD result 0x1234 -> out_valid pulses, result stays 0x1234, flags unchanged; SLL with B=32 -> shift 0, result=op_a at latency 1.
